// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner for common-anode displays with active-low segments.
// Input capture is double-buffered so that a frame never shows a mix of old and new data.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    hex_mode,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    logic [PW-1:0]                 r_presc;
    logic [IW-1:0]                 r_idx;
    logic [NUM_DIGITS-1:0][3:0]    r_pend_dig, r_act_dig;
    logic [NUM_DIGITS-1:0]         r_pend_en, r_pend_dp, r_pend_blink;
    logic [NUM_DIGITS-1:0]         r_act_en, r_act_dp, r_act_blink;
    logic [BW-1:0]                 r_bcnt;
    logic                          r_phase;
    logic [7:0]                    r_seg;
    logic [NUM_DIGITS-1:0]         r_an;
    logic                          r_frame_done;

    logic                          w_slot_end, w_wrap, w_blank, w_off;
    logic [3:0]                    w_val;
    logic [7:0]                    w_glyph;
    logic [NUM_DIGITS-1:0]         w_an;

    function automatic logic [7:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 8'h03;  4'h1: font = 8'h9F;  4'h2: font = 8'h25;  4'h3: font = 8'h0D;
            4'h4: font = 8'h99;  4'h5: font = 8'h49;  4'h6: font = 8'h41;  4'h7: font = 8'h1F;
            4'h8: font = 8'h01;  4'h9: font = 8'h09;  4'hA: font = 8'h11;  4'hB: font = 8'hC1;
            4'hC: font = 8'h63;  4'hD: font = 8'h85;  4'hE: font = 8'h61;  default: font = 8'h71;
        endcase
    endfunction

    assign w_slot_end = (r_presc == PRESC_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
    assign w_blank    = (int'(r_presc) < BLANK_CYCLES);
    assign w_val      = r_act_dig[r_idx];
    assign w_glyph    = font(w_val) & ~{7'b0, r_act_dp[r_idx]};
    assign w_off      = !r_act_en[r_idx]
                     || (r_act_blink[r_idx] && r_phase)
                     || (!hex_mode && (w_val > 4'd9));

    always_comb begin
        w_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_an[i] = (r_idx != IW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend_dig   <= '0;
            r_pend_en    <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_act_dig    <= '0;
            r_act_en     <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_seg        <= 8'hFF;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            // Outputs are computed from the pre-update state, giving one fixed cycle of latency.
            r_seg        <= (w_blank || w_off) ? 8'hFF : w_glyph;
            r_an         <= w_blank ? '1 : w_an;
            r_frame_done <= w_wrap;

            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (load) begin
                r_pend_dig   <= digits_in;
                r_pend_en    <= en_in;
                r_pend_dp    <= dp_in;
                r_pend_blink <= blink_in;
            end

            // A load coinciding with the frame boundary bypasses pending so the newest data wins.
            if (w_wrap) begin
                r_act_dig   <= load ? digits_in : r_pend_dig;
                r_act_en    <= load ? en_in     : r_pend_en;
                r_act_dp    <= load ? dp_in     : r_pend_dp;
                r_act_blink <= load ? blink_in  : r_pend_blink;
            end

            if ((BLINK_FRAMES > 0) && w_wrap) begin
                if (r_bcnt == BLINK_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt  <= r_bcnt + 1'b1;
                end
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues the hand-computed glyph of each
// digit slot, and a monitor pops and compares whenever a new digit slot appears on an.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         hex_mode = 1'b1;
    logic [15:0]  digits_in = '0;
    logic [3:0]   en_in = '0, dp_in = '0, blink_in = '0;
    logic [7:0]   seg;
    logic [3:0]   an;
    logic         frame_done;
    logic         rst_q = 1'b1;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } slot_t;

    slot_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .en_in(en_in),
        .dp_in(dp_in), .blink_in(blink_in), .hex_mode(hex_mode),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back('{an: 4'b1110, seg: s0});
        exp_q.push_back('{an: 4'b1101, seg: s1});
        exp_q.push_back('{an: 4'b1011, seg: s2});
        exp_q.push_back('{an: 4'b0111, seg: s3});
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] e,
                           input logic [3:0] p, input logic [3:0] b);
        digits_in = d; en_in = e; dp_in = p; blink_in = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns on the negedge where frame_done is seen: the new frame has just begun.
    task automatic sync_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
    endtask

    // Monitor: slot-start scoreboard plus blank/slot length, seg stability and frame period.
    initial begin : monitor
        logic [3:0] prev_an = 4'hF;
        logic [7:0] cur_seg = 8'hFF;
        int  blank_run = 0, disp_run = 0, fd_cnt = 0;
        bit  prev_active = 1'b0, have_fd = 1'b0;
        slot_t e;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                prev_active = 1'b0; have_fd = 1'b0;
                blank_run = 0; disp_run = 0; fd_cnt = 0;
                prev_an = 4'hF;
            end else begin
                fd_cnt++;
                if (frame_done) begin
                    chk("fd_on_last_digit", 32'(an), 32'h7);
                    if (have_fd) chk("fd_period", fd_cnt, 32'd32);
                    have_fd = 1'b1;
                    fd_cnt = 0;
                end
                if (an == 4'hF) begin
                    if (prev_an != 4'hF && prev_active) chk("slot_len", disp_run, SD - BC);
                    blank_run++;
                end else if (an != prev_an) begin
                    if (prev_active) chk("blank_len", blank_run, BC);
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL slot_unexpected: got an=%b seg=%h, expected none", an, seg);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_an", 32'(an), 32'(e.an));
                        chk("slot_seg", 32'(seg), 32'(e.seg));
                    end
                    prev_active = 1'b1;
                    blank_run = 0;
                    disp_run = 1;
                    cur_seg = seg;
                end else begin
                    disp_run++;
                    chk("seg_stable", 32'(seg), 32'(cur_seg));
                end
                prev_an = an;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'd0);

        // Frame 1: nothing enabled yet, an still steps.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_load(16'h3210, 4'hF, 4'h0, 4'h0);

        sync_fd();                                    // frame 2
        push_frame(8'h03, 8'h9F, 8'h25, 8'h0D);
        do_load(16'hFEDA, 4'hF, 4'h0, 4'h0);

        sync_fd();                                    // frame 3: hex
        push_frame(8'h11, 8'h85, 8'h61, 8'h71);

        sync_fd();                                    // frame 4: BCD blanks A-F
        hex_mode = 1'b0;
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        do_load(16'h8888, 4'b1011, 4'b0101, 4'h0);

        sync_fd();                                    // frame 5: dp and enable
        hex_mode = 1'b1;
        push_frame(8'h00, 8'h01, 8'hFF, 8'h01);
        do_load(16'h3210, 4'hF, 4'h0, 4'b0001);

        // Blink phase is 1 in frames 3,4,7,8 (toggles every 2 frame_done pulses from reset).
        sync_fd();  push_frame(8'h03, 8'h9F, 8'h25, 8'h0D);   // frame 6
        sync_fd();  push_frame(8'hFF, 8'h9F, 8'h25, 8'h0D);   // frame 7
        sync_fd();  push_frame(8'hFF, 8'h9F, 8'h25, 8'h0D);   // frame 8
        sync_fd();  push_frame(8'h03, 8'h9F, 8'h25, 8'h0D);   // frame 9

        sync_fd();                                    // frame 10
        push_frame(8'h03, 8'h9F, 8'h25, 8'h0D);
        do_load(16'h1111, 4'hF, 4'h0, 4'h0);          // pending only, must be overridden
        repeat (30) @(negedge clk);
        do_load(16'h7654, 4'hF, 4'h0, 4'h0);          // load held across the wrap edge
        chk("wrap_load_fd", 32'(frame_done), 32'd1);

        // Frame 11 shows the wrap-edge data; reset aborts it during digit 2.
        exp_q.push_back('{an: 4'b1110, seg: 8'h99});
        exp_q.push_back('{an: 4'b1101, seg: 8'h49});
        exp_q.push_back('{an: 4'b1011, seg: 8'h41});
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);       // buffers cleared, scan restarts at digit 0
        rst = 1'b0;

        sync_fd();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for NUM_DIGITS digits. Replaces the per-digit combinational decoder with a time-multiplexed scanner. Adds double-buffered input capture, full hex or BCD decode, per-digit enable, decimal point, blink, and anti-ghosting dead time. Sits between the application logic and the board's shared segment bus and common-anode digit selects.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
SCAN_DIV, 1000, clock cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2, dead cycles at the start of each slot with all digits off (0 allowed)
BLINK_FRAMES, 64, full frames per blink half-period; 0 disables blink

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  capture strobe for the *_in buses
digits_in  in  4*NUM_DIGITS  nibble i = value of digit i (digit 0 = bits 3:0)
en_in  in  NUM_DIGITS  per-digit enable; 0 = blank
dp_in  in  NUM_DIGITS  per-digit decimal point on
blink_in  in  NUM_DIGITS  per-digit blink enable
hex_mode  in  1  1 = decode 0-F, 0 = BCD (values 10-15 blanked)
seg  out  8  active-low segments; bit7=a, bit6=b … bit1=g, bit0=dp
an  out  NUM_DIGITS  active-low one-hot digit select
frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset values: prescaler=0, digit index=0, pending and active buffers all zero (all digits disabled), blink phase=0, seg=8'hFF, an=all ones, frame_done=0. A reset mid-frame aborts the frame immediately, with no frame_done.
- Pending buffer: when load=1, digits_in, en_in, dp_in and blink_in are captured on that edge. hex_mode is sampled live, not buffered.
- Active buffer: copied from pending on the frame-boundary edge (index wraps to 0). If load=1 on that same edge, active takes the *_in values directly, so the newest data wins. The display never tears mid-frame.
- Prescaler: counts 0..SCAN_DIV-1, then wraps to 0.
- On wrap, the index advances from N-1 to 0 with wrap-around. On the N-1 to 0 wrap, frame_done=1 for exactly that one cycle.
- Blink phase: toggles after every BLINK_FRAMES frame_done pulses (internal frame counter). It is constant 0 when BLINK_FRAMES=0.
- Slot output while prescaler < BLANK_CYCLES: an=all ones, seg=8'hFF.
- Slot output otherwise: an = ~(1<<index).
  - seg = FF if active en[index]=0, OR (blink[index]=1 AND phase=1), OR (hex_mode=0 AND value>9).
  - Else seg = font[value] with bit0 cleared when dp[index]=1.
- Font, dp off: 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71.
- seg, an and frame_done are registered. They reflect prescaler/index/buffer state one cycle later. This latency is fixed and identical for all three outputs.
- an is never more than one-hot-low. No two digits are ever driven in the same cycle.
- NUM_DIGITS=1: the index is constant 0 and frame_done pulses every SCAN_DIV cycles.

Test Plan:
Bench configuration: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset: hold rst 3 cycles -> seg=FF, an=4'b1111, frame_done=0. After release, the first full frame shows all digits blank because en=0.
- Load digits_in=16'h3210, en=4'hF, dp=0, hex_mode=1 mid-frame -> current frame still blank. Next frame digit0..3 slots show seg 03, 9F, 25, 0D with an 1110, 1101, 1011, 0111, each slot preceded by 2 cycles of an=1111.
- Hex vs BCD: digits_in=16'hFEDA, en=F -> hex_mode=1 gives 11, 85, 61, 71. hex_mode=0 gives FF on all four slots with an still stepping.
- dp and enable: dp_in=4'b0101, en_in=4'b1011, digits 8 on all -> slots: 00, 01, FF (digit2 disabled), 01.
- Blink: blink_in=4'b0001, BLINK_FRAMES=2 -> digit0 shows its glyph for 2 frames, then FF for 2 frames, alternating. Other digits are unaffected. frame_done pulses every 32 cycles.
- Boundary: assert load on the exact frame-wrap edge with new data -> the new data is displayed in the immediately starting frame. Assert rst during the digit-2 slot -> next cycle an=1111 and seg=FF, and the scan restarts at digit 0.
